// File: rtl/alu_sequencer.sv
// Sequences one operation at a time through an external 32-bit ALU: decode, execute, hold response.
// Optional completed-response counter on op_cnt enabled by defining ALU_SEQUENCER_OPCNT_EN.
module alu_sequencer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  alu_op,
  input  logic [5:0]  funct,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  output logic [31:0] alu_src1,
  output logic [31:0] alu_src2,
  output logic [3:0]  alu_ctrl,
  input  logic [31:0] alu_result,
  input  logic        alu_zero,
  input  logic        alu_cout,
  input  logic        alu_overflow,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_result,
  output logic        rsp_zero,
  output logic        rsp_cout,
  output logic        rsp_overflow,
  output logic        rsp_illegal,
  output logic [15:0] op_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] alu_src1_q, alu_src1_d;
  logic [31:0] alu_src2_q, alu_src2_d;
  logic [3:0]  alu_ctrl_q, alu_ctrl_d;
  logic [31:0] rsp_result_q, rsp_result_d;
  logic        rsp_zero_q, rsp_zero_d;
  logic        rsp_cout_q, rsp_cout_d;
  logic        rsp_overflow_q, rsp_overflow_d;
  logic        rsp_illegal_q, rsp_illegal_d;

  logic        dec_legal;
  logic [3:0]  dec_ctrl;
  logic        rsp_hs;

  // NOTE: every signal assigned in an always_comb gets a default first; a path
  // that leaves one unassigned would infer a latch.
  always_comb begin
    dec_legal = 1'b1;
    dec_ctrl  = 4'b0000;
    unique case (alu_op)
      2'b00: dec_ctrl = 4'b0010;
      2'b01: dec_ctrl = 4'b0110;
      2'b10: begin
        unique case (funct)
          6'b100000: dec_ctrl = 4'b0010;
          6'b100010: dec_ctrl = 4'b0110;
          6'b100100: dec_ctrl = 4'b0000;
          6'b100101: dec_ctrl = 4'b0001;
          6'b100111: dec_ctrl = 4'b1100;
          6'b101010: dec_ctrl = 4'b0111;
          default:   dec_legal = 1'b0;
        endcase
      end
      default: dec_legal = 1'b0;
    endcase
  end

  always_comb begin
    state_d        = state_q;
    alu_src1_d     = alu_src1_q;
    alu_src2_d     = alu_src2_q;
    alu_ctrl_d     = alu_ctrl_q;
    rsp_result_d   = rsp_result_q;
    rsp_zero_d     = rsp_zero_q;
    rsp_cout_d     = rsp_cout_q;
    rsp_overflow_d = rsp_overflow_q;
    rsp_illegal_d  = rsp_illegal_q;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (dec_legal) begin
            alu_src1_d = op_a;
            alu_src2_d = op_b;
            alu_ctrl_d = dec_ctrl;
            state_d    = EXEC;
          end else begin
            // Illegal ops skip the ALU and leave its drive untouched.
            rsp_result_d   = '0;
            rsp_zero_d     = 1'b0;
            rsp_cout_d     = 1'b0;
            rsp_overflow_d = 1'b0;
            rsp_illegal_d  = 1'b1;
            state_d        = RESP;
          end
        end
      end
      EXEC: begin
        rsp_result_d   = alu_result;
        rsp_zero_d     = alu_zero;
        rsp_cout_d     = alu_cout;
        rsp_overflow_d = alu_overflow;
        rsp_illegal_d  = 1'b0;
        state_d        = RESP;
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      alu_src1_q     <= '0;
      alu_src2_q     <= '0;
      alu_ctrl_q     <= '0;
      rsp_result_q   <= '0;
      rsp_zero_q     <= 1'b0;
      rsp_cout_q     <= 1'b0;
      rsp_overflow_q <= 1'b0;
      rsp_illegal_q  <= 1'b0;
    end else begin
      state_q        <= state_d;
      alu_src1_q     <= alu_src1_d;
      alu_src2_q     <= alu_src2_d;
      alu_ctrl_q     <= alu_ctrl_d;
      rsp_result_q   <= rsp_result_d;
      rsp_zero_q     <= rsp_zero_d;
      rsp_cout_q     <= rsp_cout_d;
      rsp_overflow_q <= rsp_overflow_d;
      rsp_illegal_q  <= rsp_illegal_d;
    end
  end

  assign rsp_hs = (state_q == RESP) && rsp_ready;

`ifdef ALU_SEQUENCER_OPCNT_EN
  logic [15:0] op_cnt_q, op_cnt_d;

  always_comb begin
    op_cnt_d = op_cnt_q;
    if (rsp_hs) op_cnt_d = op_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) op_cnt_q <= '0;
    else        op_cnt_q <= op_cnt_d;
  end

  assign op_cnt = op_cnt_q;
`else
  logic unused_hs;
  assign unused_hs = rsp_hs;
  assign op_cnt    = '0;
`endif

  // Gate with rst_n so the handshake is refused while reset is held.
  assign req_ready    = (state_q == IDLE) && rst_n;
  assign rsp_valid    = (state_q == RESP);
  assign alu_src1     = alu_src1_q;
  assign alu_src2     = alu_src2_q;
  assign alu_ctrl     = alu_ctrl_q;
  assign rsp_result   = rsp_result_q;
  assign rsp_zero     = rsp_zero_q;
  assign rsp_cout     = rsp_cout_q;
  assign rsp_overflow = rsp_overflow_q;
  assign rsp_illegal  = rsp_illegal_q;

endmodule

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 The module SHALL have ports: clk  in  1  single clock, all state on rising edge.
REQ-002 The module SHALL have ports: rst_n  in  1  reset, asynchronous, active-low.
REQ-003 The module SHALL have ports: req_valid  in  1 / req_ready  out  1  operation request handshake.
REQ-004 The module SHALL have ports: alu_op  in  2  op class (00 add, 01 sub, 10 R-type, 11 reserved); funct  in  6  R-type function field.
REQ-005 The module SHALL have ports: op_a  in  32 / op_b  in  32  operands.
REQ-006 The module SHALL have ports: alu_src1  out  32 / alu_src2  out  32 / alu_ctrl  out  4  drive to the 32-bit ALU.
REQ-007 The module SHALL have ports: alu_result  in  32 / alu_zero  in  1 / alu_cout  in  1 / alu_overflow  in  1  ALU return.
REQ-008 The module SHALL have ports: rsp_valid  out  1 / rsp_ready  in  1  response handshake.
REQ-009 The module SHALL have ports: rsp_result  out  32 / rsp_zero, rsp_cout, rsp_overflow, rsp_illegal  out  1 each.
REQ-010 The module SHALL have port op_cnt  out  16  completed-response counter (see Configuration).

Function
REQ-011 The FSM SHALL have states IDLE, EXEC and RESP; req_ready=1 only in IDLE; rsp_valid=1 only in RESP.
REQ-012 In IDLE with req_valid=1, the module SHALL register op_a->alu_src1, op_b->alu_src2 and the decoded code->alu_ctrl on that edge.
REQ-013 Decode SHALL be: alu_op 00->0010; 01->0110; 10 with funct 100000->0010, 100010->0110, 100100->0000, 100101->0001, 100111->1100, 101010->0111.
REQ-014 alu_op 11, or alu_op 10 with any other funct, SHALL be illegal: IDLE->RESP directly, rsp_illegal=1, rsp_result=0, all flags 0, alu_src1/alu_src2/alu_ctrl unchanged.
REQ-015 Legal request: IDLE->EXEC; EXEC SHALL last exactly one cycle, at its end capture alu_result/zero/cout/overflow into rsp_* with rsp_illegal=0, then ->RESP.
REQ-016 Latency SHALL be: request accepted at edge N, rsp_valid high from edge N+2 (legal) or N+1 (illegal).
REQ-017 alu_src1, alu_src2 and alu_ctrl SHALL stay stable from acceptance until the next acceptance.
REQ-018 In RESP, rsp_* SHALL hold stable until rsp_ready=1; on that edge ->IDLE, rsp_valid drops next cycle.
REQ-019 req_valid in EXEC/RESP SHALL be ignored (not accepted); max throughput is one op per 3 cycles.
REQ-020 rsp_ready asserted outside RESP SHALL have no effect.

Reset
REQ-021 rst_n low SHALL immediately force IDLE and clear alu_src1, alu_src2, alu_ctrl, rsp_result, all rsp flags, rsp_valid and op_cnt to 0; req_ready=1 while rst_n is high in IDLE, 0 during reset.
REQ-022 Reset during EXEC or RESP SHALL discard the in-flight operation; no response is produced for it.

Configuration
REQ-023 With macro ALU_SEQUENCER_OPCNT_EN defined, op_cnt SHALL increment by 1 on each rsp handshake (legal or illegal), wrapping 0xFFFF->0x0000.
REQ-024 Without ALU_SEQUENCER_OPCNT_EN, op_cnt SHALL be constant 0 and no counter register SHALL be built.

Verification
REQ-025 add: alu_op=00, op_a=0x7FFFFFFF, op_b=1 -> alu_ctrl=0010, rsp_valid at N+2, rsp_result/flags equal ALU outputs for 0x7FFFFFFF+1, rsp_illegal=0.
REQ-026 slt: alu_op=10, funct=101010, op_a=0xFFFFFFFF, op_b=1 -> alu_ctrl=0111, rsp_result equals ALU output, alu_src1/alu_src2 held through RESP.
REQ-027 illegal: alu_op=10, funct=000000 -> rsp_valid at N+1, rsp_illegal=1, rsp_result=0, alu_ctrl unchanged from previous op.
REQ-028 backpressure: rsp_ready=0 for 5 cycles with req_valid=1 throughout -> rsp_* stable, req_ready=0, second request accepted only in the cycle after the rsp handshake.
REQ-029 reset: rst_n low mid-EXEC -> outputs 0 asynchronously, no rsp_valid after release, next request completes normally.
REQ-030 counter (macro on): 65537 handshakes -> op_cnt=1; macro off -> op_cnt=0 throughout.
